// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel processing stream.
//  - pixel width / max value
//  - operation select codes carried on cfg_select / op_select
//  - frame reader state encoding
//  - payload carried through the reader's skid buffer
package pixel_pkg;

   localparam int unsigned PIX_W = 8;
   localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

   localparam logic [1:0] SEL_BRIGHT_UP = 2'b00;
   localparam logic [1:0] SEL_BRIGHT_DN = 2'b01;
   localparam logic [1:0] SEL_THRESH    = 2'b10;
   localparam logic [1:0] SEL_INVERT    = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   typedef struct packed {
      logic [PIX_W-1:0] pixel;
   } pix_beat_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO between the frame buffer read port and the pixel output.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  push/push_data write one pixel (caller guarantees space)
//  pop            remove head entry (caller guarantees non-empty)
//  head_pixel_c   current head entry (combinational mux of storage)
//  count          registered occupancy 0..2, used for read credit
module pixel_skid_fifo
   import pixel_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [PIX_W-1:0] push_data,
   input  logic             pop,
   output logic [PIX_W-1:0] head_pixel_c,
   output logic [1:0]       count
);

   pix_beat_t  ent0_q, ent0_d;
   pix_beat_t  ent1_q, ent1_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;

   // Next-state: write at wr_ptr, read at rd_ptr, occupancy tracks both.
   always_comb begin
      ent0_d   = ent0_q;
      ent1_d   = ent1_q;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + 2'(push) - 2'(pop);
      if (push) begin
         if (wr_ptr_q) ent1_d.pixel = push_data;
         else          ent0_d.pixel = push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_pixel_c = rd_ptr_q ? ent1_q.pixel : ent0_q.pixel;
   assign count        = count_q;

endmodule

// File: rtl/pixel_frame_reader.sv
// Walks the frame buffer in raster order and streams one pixel per
// valid/ready handshake with sof/eol/eof markers; latches the operation
// config at frame start and holds it on op_* for the whole frame.
// Ports:
//  clk, rst_n                      clock, async active-low reset
//  start, cfg_select/value/thresh  frame request and config (sampled in IDLE)
//  busy, done                      frame in progress / one-cycle completion pulse
//  mem_rd_en, mem_addr, mem_rdata  frame buffer read port (1-cycle latency)
//  out_valid, out_ready, out_pixel pixel stream handshake
//  out_sof, out_eol, out_eof       frame/line markers, qualified by out_valid
//  op_select, op_value, op_thresh  latched config for the pixel operator
module pixel_frame_reader
   import pixel_pkg::*;
#(
   parameter int unsigned IMG_W  = 64,
   parameter int unsigned IMG_H  = 64,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        cfg_select,
   input  logic [7:0]        cfg_value,
   input  logic [7:0]        cfg_thresh,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_pixel,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof,
   output logic [1:0]        op_select,
   output logic [7:0]        op_value,
   output logic [7:0]        op_thresh
);

   localparam int unsigned PIX_CNT = IMG_W * IMG_H;
   localparam int unsigned COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_CNT - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_FETCH = FETCH;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              inflight_q, inflight_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        op_select_q, op_select_d;
   logic [7:0]        op_value_q, op_value_d;
   logic [7:0]        op_thresh_q, op_thresh_d;

   logic [1:0]        fifo_count;
   logic [PIX_W-1:0]  head_pixel_c;
   logic              xfer_c;
   logic              last_col_c;
   logic              last_row_c;
   logic              rd_credit_c;
   logic              rd_en_c;

   assign out_valid  = (fifo_count != 2'd0);
   assign xfer_c     = out_valid & out_ready;
   assign last_col_c = (col_q == LAST_COL);
   assign last_row_c = (row_q == LAST_ROW);

   // Buffer space after this edge (held + arriving - leaving) must leave a
   // slot for the read issued now, which lands one edge later.
   assign rd_credit_c = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, xfer_c});
   assign rd_en_c     = (state_q == ST_FETCH) && rd_credit_c;

   pixel_skid_fifo u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (inflight_q),
      .push_data    (mem_rdata),
      .pop          (xfer_c),
      .head_pixel_c (head_pixel_c),
      .count        (fifo_count)
   );

   // Next-state: frame FSM, read address, raster position, config latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      col_d       = col_q;
      row_d       = row_q;
      inflight_d  = rd_en_c;
      busy_d      = busy_q;
      done_d      = 1'b0;
      op_select_d = op_select_q;
      op_value_d  = op_value_q;
      op_thresh_d = op_thresh_q;

      if (xfer_c) begin
         if (last_col_c) begin
            col_d = '0;
            row_d = last_row_c ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_FETCH;
               addr_d      = '0;
               col_d       = '0;
               row_d       = '0;
               busy_d      = 1'b1;
               op_select_d = cfg_select;
               op_value_d  = cfg_value;
               op_thresh_d = cfg_thresh;
            end
         end
         ST_FETCH: begin
            // Address parks on the last pixel once it has been issued.
            if (rd_en_c) begin
               if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
               else                     addr_d  = addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (xfer_c && last_col_c && last_row_c) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         inflight_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         op_select_q <= 2'b00;
         op_value_q  <= 8'h00;
         op_thresh_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         inflight_q  <= inflight_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         op_select_q <= op_select_d;
         op_value_q  <= op_value_d;
         op_thresh_q <= op_thresh_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_rd_en = rd_en_c;
   assign mem_addr  = addr_q;
   assign out_pixel = out_valid ? head_pixel_c : 8'h00;
   assign out_sof   = out_valid & (col_q == '0) & (row_q == '0);
   assign out_eol   = out_valid & last_col_c;
   assign out_eof   = out_valid & last_col_c & last_row_c;
   assign op_select = op_select_q;
   assign op_value  = op_value_q;
   assign op_thresh = op_thresh_q;

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Bench for pixel_frame_reader on a 4x3 frame with a 1-cycle-latency RAM.
// Expected beats {eof,eol,sof,pixel} are queued when a frame is started and
// compared against the beats the reader hands over.
module tb_pixel_frame_reader;
   import pixel_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned AW = 4;
   localparam int N = W * H;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    cfg_select;
   logic [7:0]    cfg_value;
   logic [7:0]    cfg_thresh;
   logic          busy, done, mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          out_valid, out_ready;
   logic [7:0]    out_pixel;
   logic          out_sof, out_eol, out_eof;
   logic [1:0]    op_select;
   logic [7:0]    op_value, op_thresh;

   int checks = 0;
   int failures = 0;

   logic [7:0]  ram [0:15];
   logic [10:0] sb_q [$];
   logic [10:0] obs_q [$];
   int          cyc_q [$];
   int          hold_bad;
   logic [1:0]  op_or;
   bit          timed_out;

   logic clr_mon = 1'b0;
   int   rd_cnt = 0, xf_cnt = 0, max_out = 0, max_addr = 0;

   always #5 clk = ~clk;

   pixel_frame_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_select(cfg_select), .cfg_value(cfg_value), .cfg_thresh(cfg_thresh),
      .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
      .op_select(op_select), .op_value(op_value), .op_thresh(op_thresh)
   );

   // Frame buffer: data for a read appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
   end

   // Read/transfer bookkeeping: totals, highest address, peak outstanding.
   always @(posedge clk) begin
      if (clr_mon) begin
         rd_cnt <= 0; xf_cnt <= 0; max_out <= 0; max_addr <= 0;
      end else begin
         rd_cnt <= rd_cnt + (mem_rd_en ? 1 : 0);
         xf_cnt <= xf_cnt + ((out_valid && out_ready) ? 1 : 0);
         if (mem_rd_en && int'(mem_addr) > max_addr) max_addr <= int'(mem_addr);
         if (rd_cnt + (mem_rd_en ? 1 : 0) - xf_cnt - ((out_valid && out_ready) ? 1 : 0) > max_out)
            max_out <= rd_cnt + (mem_rd_en ? 1 : 0) - xf_cnt - ((out_valid && out_ready) ? 1 : 0);
      end
   end

   task automatic clear_monitor;
      clr_mon = 1'b1;
      @(negedge clk);
      clr_mon = 1'b0;
   endtask

   // Queue the beats the current RAM contents should produce, in raster order.
   task automatic push_frame;
      for (int i = 0; i < N; i++)
         sb_q.push_back({(i == N - 1), ((i % W) == W - 1), (i == 0), ram[i]});
   endtask

   // Called just after a negedge; returns in the cycle after start is sampled.
   task automatic start_frame(input logic [1:0] sel, input logic [7:0] val, input logic [7:0] thr);
      cfg_select = sel; cfg_value = val; cfg_thresh = thr;
      start = 1'b1;
      push_frame();
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive out_ready per mode (0 always, 1 five-cycle stall, 2 random) and
   // record handed-over beats; poke pulses start and flips cfg mid-frame.
   task automatic stream(input int n, input int mode, input int stall_at, input bit poke);
      int         cyc;
      logic       held_v;
      logic [10:0] held;
      obs_q.delete(); cyc_q.delete();
      hold_bad = 0; op_or = 2'b00; held_v = 1'b0; held = '0; cyc = 0;
      while (obs_q.size() < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke) begin
            start = (cyc == 4);
            if (cyc == 4) begin
               cfg_select = SEL_INVERT; cfg_value = 8'hEE; cfg_thresh = 8'h11;
            end
         end
         op_or = op_or | op_select;
         if (held_v && (!out_valid || {out_eof, out_eol, out_sof, out_pixel} !== held))
            hold_bad++;
         held_v = out_valid && !out_ready;
         held   = {out_eof, out_eol, out_sof, out_pixel};
         if (out_valid && out_ready) begin
            obs_q.push_back({out_eof, out_eol, out_sof, out_pixel});
            cyc_q.push_back(cyc);
         end
      end
      timed_out = (obs_q.size() < n);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      cfg_select = 2'b00; cfg_value = 8'h00; cfg_thresh = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, mem_rd_en, mem_addr, out_valid, out_pixel, out_sof, out_eol, out_eof,
           op_select, op_value, op_thresh} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b done=%b rd=%b addr=%0d valid=%b pix=%h op=%b/%h/%h, required all 0",
                  busy, done, mem_rd_en, mem_addr, out_valid, out_pixel, op_select, op_value, op_thresh);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, mem_rd_en, out_valid} !== 4'b0000) begin
         failures++;
         $display("FAIL idle_after_reset: busy=%b done=%b rd=%b valid=%b, required 0000",
                  busy, done, mem_rd_en, out_valid);
      end
   endtask

   task automatic test_basic;
      logic [10:0] e;
      for (int i = 0; i < 16; i++) ram[i] = 8'(i);
      out_ready = 1'b1;
      clear_monitor();
      start_frame(SEL_BRIGHT_UP, 8'h10, 8'h80);
      checks++;
      if ({mem_rd_en, out_valid, busy, mem_addr} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
         failures++;
         $display("FAIL basic_first_read: rd=%b valid=%b busy=%b addr=%0d, required 1 0 1 0",
                  mem_rd_en, out_valid, busy, mem_addr);
      end
      checks++;
      if ({op_select, op_value, op_thresh} !== {SEL_BRIGHT_UP, 8'h10, 8'h80}) begin
         failures++;
         $display("FAIL basic_op_latch: op=%b/%h/%h, required 00/10/80", op_select, op_value, op_thresh);
      end
      stream(N, 0, 0, 1'b0);
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL basic_timeout: got %0d beats, required %0d", obs_q.size(), N);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL basic_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      checks++;
      if (cyc_q.size() != N || cyc_q[0] != 2 || cyc_q[N-1] != N + 1) begin
         failures++;
         $display("FAIL basic_timing: first=%0d last=%0d, required 2 and %0d",
                  (cyc_q.size() > 0) ? cyc_q[0] : -1, (cyc_q.size() == N) ? cyc_q[N-1] : -1, N + 1);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL basic_done: busy=%b done=%b, required 0 1", busy, done);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL basic_done_pulse: busy=%b done=%b, required 0 0", busy, done);
      end
      checks++;
      if (rd_cnt != N || max_addr != N - 1) begin
         failures++;
         $display("FAIL basic_reads: reads=%0d max_addr=%0d, required %0d and %0d", rd_cnt, max_addr, N, N - 1);
      end
   endtask

   task automatic test_stall;
      logic [10:0] e;
      clear_monitor();
      start_frame(SEL_BRIGHT_DN, 8'h04, 8'h40);
      stream(N, 1, 5, 1'b0);
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL stall_timeout: got %0d beats, required %0d", obs_q.size(), N);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL stall_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      checks++;
      if (hold_bad != 0) begin
         failures++;
         $display("FAIL stall_hold: %0d unstable stalled cycles, required 0", hold_bad);
      end
      checks++;
      if (max_out > 2 || rd_cnt != N || max_addr != N - 1) begin
         failures++;
         $display("FAIL stall_reads: outstanding=%0d reads=%0d max_addr=%0d, required <=2, %0d, %0d",
                  max_out, rd_cnt, max_addr, N, N - 1);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL stall_done: busy=%b done=%b, required 0 1", busy, done);
      end
   endtask

   task automatic test_random;
      logic [10:0] e;
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      clear_monitor();
      start_frame(SEL_THRESH, 8'h00, 8'h7F);
      stream(N, 2, 0, 1'b0);
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL random_timeout: got %0d beats, required %0d", obs_q.size(), N);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL random_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      checks++;
      if (hold_bad != 0 || max_out > 2) begin
         failures++;
         $display("FAIL random_flow: unstable=%0d outstanding=%0d, required 0 and <=2", hold_bad, max_out);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL random_done: busy=%b done=%b, required 0 1", busy, done);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL random_done_pulse: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_busy_start;
      logic [10:0] e;
      start_frame(SEL_BRIGHT_UP, 8'h22, 8'h33);
      stream(N, 0, 0, 1'b1);
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL busy_start_timeout: got %0d beats, required %0d", obs_q.size(), N);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL busy_start_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      checks++;
      if (op_or !== 2'b00 || {op_value, op_thresh} !== {8'h22, 8'h33}) begin
         failures++;
         $display("FAIL busy_start_op: op_select_or=%b value=%h thresh=%h, required 00/22/33",
                  op_or, op_value, op_thresh);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL busy_start_done: done=%b, required 1", done);
      end
      @(negedge clk);
      checks++;
      if ({busy, mem_rd_en} !== 2'b00) begin
         failures++;
         $display("FAIL busy_start_restart: busy=%b rd=%b, required 0 0", busy, mem_rd_en);
      end
   endtask

   task automatic test_reset_mid;
      logic [10:0] e;
      for (int i = 0; i < 16; i++) ram[i] = 8'(8'hA0 + i);
      out_ready = 1'b1;
      start_frame(SEL_THRESH, 8'h00, 8'h50);
      stream(6, 0, 0, 1'b0);
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL midrst_pre_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_rd_en, mem_addr, out_valid, out_pixel, out_sof, out_eol, out_eof,
           op_select, op_value, op_thresh} !== '0) begin
         failures++;
         $display("FAIL midrst_outputs: busy=%b rd=%b addr=%0d valid=%b pix=%h op=%b/%h, required all 0",
                  busy, mem_rd_en, mem_addr, out_valid, out_pixel, op_select, op_thresh);
      end
      @(negedge clk);
      checks++;
      if ({mem_rd_en, out_valid} !== 2'b00) begin
         failures++;
         $display("FAIL midrst_hold: rd=%b valid=%b, required 0 0", mem_rd_en, out_valid);
      end
      rst_n = 1'b1;
      sb_q.delete();
      @(negedge clk);
      clear_monitor();
      start_frame(SEL_BRIGHT_DN, 8'h09, 8'h50);
      stream(N, 0, 0, 1'b0);
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL midrst_timeout: got %0d beats, required %0d", obs_q.size(), N);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL midrst_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL midrst_done: busy=%b done=%b, required 0 1", busy, done);
      end
   endtask

   task automatic test_back_to_back;
      logic [10:0] e;
      for (int i = 0; i < 16; i++) ram[i] = 8'(8'hF0 - 3 * i);
      @(negedge clk);
      start_frame(SEL_THRESH, 8'h05, 8'h40);
      stream(N, 0, 0, 1'b0);
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL b2b_f1_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL b2b_done: busy=%b done=%b, required 0 1", busy, done);
      end
      start_frame(SEL_INVERT, 8'h07, 8'h90);
      checks++;
      if ({busy, done, mem_rd_en, op_select, op_value, op_thresh} !== {3'b101, SEL_INVERT, 8'h07, 8'h90}) begin
         failures++;
         $display("FAIL b2b_restart: busy=%b done=%b rd=%b op=%b/%h/%h, required 1 0 1 11/07/90",
                  busy, done, mem_rd_en, op_select, op_value, op_thresh);
      end
      stream(N, 0, 0, 1'b0);
      checks++;
      if (timed_out || cyc_q.size() == 0 || cyc_q[0] != 2) begin
         failures++;
         $display("FAIL b2b_f2_flow: beats=%0d first=%0d, required %0d and 2",
                  obs_q.size(), (cyc_q.size() > 0) ? cyc_q[0] : -1, N);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         e = sb_q.pop_front();
         checks++;
         if (obs_q[i] !== e) begin
            failures++;
            $display("FAIL b2b_f2_beat%0d: got %h, required %h", i, obs_q[i], e);
         end
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL b2b_f2_done: busy=%b done=%b, required 0 1", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random();
      test_busy_start();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
